// File: rtl/decode_exec_stage_xl.sv
// Decode/execute stage: register file, immediates, forwarding, ALU, branch compare, pipeline registers.
// Optional iterative RV M-extension multiply/divide unit enabled by defining MULDIV_EN.
module decode_exec_stage_xl #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter logic [31:0] NOP   = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            stall,
  input  logic            reg_wr,
  input  logic            A_sel,
  input  logic            B_sel,
  input  logic            forw_a,
  input  logic            forw_b,
  input  logic [3:0]      ALUctrl,
  input  logic [31:0]     instruction,
  input  logic [XLEN-1:0] PC,
  input  logic [XLEN-1:0] wdata,
  output logic            br_taken,
  output logic            md_busy,
  output logic [XLEN-1:0] PC_ppl,
  output logic [XLEN-1:0] ALU_ppl,
  output logic [XLEN-1:0] rdata1_ppl,
  output logic [XLEN-1:0] rdata2_ppl,
  output logic [31:0]     instruction_ppl
);

  localparam int unsigned RW = $clog2(NREGS);
  localparam int unsigned SW = $clog2(XLEN);
  localparam int unsigned CW = $clog2(XLEN) + 1;

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [RW-1:0]   rs1_idx, rs2_idx, rd_idx;
  logic [XLEN-1:0] rf [NREGS];
  logic [XLEN-1:0] rs1_d, rs2_d, rs1_f, rs2_f;
  logic [XLEN-1:0] imm, op_a, op_b, alu_res, alu_in;
  logic signed [31:0] imm32;
  logic [SW-1:0]   shamt;

  assign opcode  = instruction[6:0];
  assign f3      = instruction[14:12];
  assign rs1_idx = instruction[15 +: RW];
  assign rs2_idx = instruction[20 +: RW];
  assign rd_idx  = instruction_ppl[7 +: RW];

  always_ff @(posedge clk) begin
    if (reg_wr && (rd_idx != '0))
      rf[rd_idx] <= wdata;
  end

  assign rs1_d = (rs1_idx == '0) ? '0 : rf[rs1_idx];
  assign rs2_d = (rs2_idx == '0) ? '0 : rf[rs2_idx];
  assign rs1_f = forw_a ? ALU_ppl : rs1_d;
  assign rs2_f = forw_b ? ALU_ppl : rs2_d;

  always_comb begin
    imm32 = '0;
    case (opcode)
      7'b0000011, 7'b0010011, 7'b1100111:
        imm32 = {{20{instruction[31]}}, instruction[31:20]};
      7'b0100011:
        imm32 = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
      7'b1100011:
        imm32 = {{19{instruction[31]}}, instruction[31], instruction[7],
                 instruction[30:25], instruction[11:8], 1'b0};
      7'b1101111:
        imm32 = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                 instruction[20], instruction[30:21], 1'b0};
      7'b0110111, 7'b0010111:
        imm32 = {instruction[31:12], 12'b0};
      default: imm32 = '0;
    endcase
  end
  assign imm = XLEN'(imm32);

  assign op_a  = A_sel ? rs1_f : PC;
  assign op_b  = B_sel ? imm : rs2_f;
  assign shamt = op_b[SW-1:0];

  // ALUctrl: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 pass B
  always_comb begin
    alu_res = '0;
    case (ALUctrl)
      4'd0:    alu_res = op_a + op_b;
      4'd1:    alu_res = op_a - op_b;
      4'd2:    alu_res = op_a & op_b;
      4'd3:    alu_res = op_a | op_b;
      4'd4:    alu_res = op_a ^ op_b;
      4'd5:    alu_res = op_a << shamt;
      4'd6:    alu_res = op_a >> shamt;
      4'd7:    alu_res = $signed(op_a) >>> shamt;
      4'd8:    alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      4'd9:    alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      4'd10:   alu_res = op_b;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    case (f3)
      3'b000:  br_taken = (rs1_f == rs2_f);
      3'b001:  br_taken = (rs1_f != rs2_f);
      3'b100:  br_taken = ($signed(rs1_f) <  $signed(rs2_f));
      3'b101:  br_taken = ($signed(rs1_f) >= $signed(rs2_f));
      3'b110:  br_taken = (rs1_f <  rs2_f);
      3'b111:  br_taken = (rs1_f >= rs2_f);
      default: br_taken = 1'b0;
    endcase
  end

`ifdef MULDIV_EN
  typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

  md_state_t         state, state_nxt;
  logic              md_start, a_sgn, b_sgn, neg_a, neg_b, b_zero;
  logic [2:0]        md_f3;
  logic [CW-1:0]     cnt;
  logic [XLEN-1:0]   a_mag, b_mag, dvs, rs1_hold, quo, rem, md_result;
  logic [XLEN:0]     sum, shl, diff;
  logic [2*XLEN-1:0] acc, acc_step, prod;

  assign md_start = (state == IDLE) && (opcode == 7'b0110011) &&
                    (instruction[31:25] == 7'b0000001) && !flush;
  assign md_busy  = md_start | (state == BUSY);

  always_comb begin
    a_sgn = f3[2] ? !f3[0] : (f3 != 3'b011);
    b_sgn = f3[2] ? !f3[0] : !f3[1];
    a_mag = (a_sgn && rs1_f[XLEN-1]) ? -rs1_f : rs1_f;
    b_mag = (b_sgn && rs2_f[XLEN-1]) ? -rs2_f : rs2_f;
  end

  // acc holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV
  always_comb begin
    sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, dvs} : '0);
    shl  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    diff = shl - {1'b0, dvs};
    if (md_f3[2])
      acc_step = diff[XLEN] ? {shl[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                            : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    else
      acc_step = {sum, acc[XLEN-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      dvs      <= '0;
      rs1_hold <= '0;
      md_f3    <= '0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      b_zero   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (md_start) begin
        acc      <= {{XLEN{1'b0}}, a_mag};
        dvs      <= b_mag;
        rs1_hold <= rs1_f;
        md_f3    <= f3;
        neg_a    <= a_sgn & rs1_f[XLEN-1];
        neg_b    <= b_sgn & rs2_f[XLEN-1];
        b_zero   <= (rs2_f == '0);
        cnt      <= CW'(XLEN);
      end else if (state == BUSY) begin
        acc <= acc_step;
        cnt <= cnt - 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (md_start) state_nxt = BUSY;
      BUSY:    if (flush) state_nxt = IDLE;
               else if (cnt == CW'(1)) state_nxt = DONE;
      DONE:    if (flush || !stall) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    prod = (neg_a ^ neg_b) ? -acc : acc;
    quo  = acc[XLEN-1:0];
    rem  = acc[2*XLEN-1:XLEN];
    if (!md_f3[2])
      md_result = (md_f3[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    else if (b_zero)
      md_result = md_f3[1] ? rs1_hold : '1;
    else if (md_f3[1])
      md_result = neg_a ? -rem : rem;
    else
      md_result = (neg_a ^ neg_b) ? -quo : quo;
  end

  assign alu_in = (state == DONE) ? md_result : alu_res;
`else
  assign md_busy = 1'b0;
  assign alu_in  = alu_res;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PC_ppl          <= '0;
      ALU_ppl         <= '0;
      rdata1_ppl      <= '0;
      rdata2_ppl      <= '0;
      instruction_ppl <= '0;
    end else if (flush) begin
      PC_ppl          <= '0;
      ALU_ppl         <= '0;
      rdata1_ppl      <= '0;
      rdata2_ppl      <= '0;
      instruction_ppl <= NOP;
    end else if (!(stall || md_busy)) begin
      PC_ppl          <= PC;
      ALU_ppl         <= alu_in;
      rdata1_ppl      <= rs1_f;
      rdata2_ppl      <= rs2_f;
      instruction_ppl <= instruction;
    end
  end

endmodule
